// File: rtl/rv32i_types.sv
// Shared RV32I core types: register index, data word and the
// forwarding watchdog state encoding.
package rv32i_types;

  typedef logic [4:0]  rv32i_reg;
  typedef logic [31:0] rv32i_word;

  // Watchdog states: RUN (no stall), WAIT (counting stall cycles),
  // TOUT (stall persisted too long, flag raised until cleared).
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    TOUT = 2'd2
  } fwd_state_t;

endpackage

// File: rtl/fwd_scoreboard.sv
// Register scoreboard for long-latency (mul/div) destinations. A bit is
// busy from the cycle after issue until the cycle after its result lands.
module fwd_scoreboard
  import rv32i_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      lat_issue,
  input  rv32i_reg  lat_issue_dest,
  input  logic      lat_done,
  input  rv32i_reg  lat_done_dest,
  output rv32i_word sb_busy
);

  rv32i_word busy_d;
  rv32i_word busy_q;

  // Clear on completion first, then set on issue, so a same-register
  // issue/done pair leaves the bit busy for the newer operation.
  // Writes to x0 never create a dependency.
  always_comb begin
    busy_d = busy_q;
    if (lat_done) begin
      busy_d[lat_done_dest] = 1'b0;
    end
    if (lat_issue && (lat_issue_dest != 5'd0)) begin
      busy_d[lat_issue_dest] = 1'b1;
    end
  end

  // Busy vector register, emptied by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign sb_busy = busy_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and hazard detection between ID/EX operand read and
// EX. Picks the youngest in-flight producer per source operand, detects
// load-use and scoreboard hazards, and watches for stalls that never end.
module fwd_hazard_unit
  import rv32i_types::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int TIMEOUT    = 64,
  localparam int SW        = $clog2(NUM_STAGES + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                src_valid,
  input  logic [NUM_SRC-1:0][4:0]           src_addr,
  input  logic [NUM_STAGES-1:0]             stg_ld_regfile,
  input  logic [NUM_STAGES-1:0][4:0]        stg_dest,
  input  logic [NUM_STAGES-1:0][31:0]       stg_data,
  input  logic [NUM_STAGES-1:0]             stg_ready,
  input  logic                              lat_issue,
  input  rv32i_reg                          lat_issue_dest,
  input  logic                              lat_done,
  input  rv32i_reg                          lat_done_dest,
  input  rv32i_word                         lat_done_data,
  input  logic                              timeout_clr,
  output logic [NUM_SRC-1:0]                fwd_hit,
  output logic [NUM_SRC-1:0][31:0]          fwd_data,
  output logic [NUM_SRC-1:0][SW-1:0]        fwd_src,
  output logic                              stall,
  output rv32i_word                         sb_busy,
  output logic                              hazard_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [NUM_SRC-1:0] opStall;
  logic [NUM_SRC-1:0] opFound;
  logic               stallInt;
  fwd_state_t         state_q;
  logic [CW-1:0]      stallCnt_q;
  logic               timeout_q;

  fwd_scoreboard u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .lat_issue      (lat_issue),
    .lat_issue_dest (lat_issue_dest),
    .lat_done       (lat_done),
    .lat_done_dest  (lat_done_dest),
    .sb_busy        (sb_busy)
  );

  // Per-operand priority select: youngest matching stage wins outright
  // (a not-ready winner is a load-use stall with no fallback to older
  // stages), then the completing long-latency result, then the scoreboard.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    fwd_src  = '0;
    opStall  = '0;
    opFound  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst && src_valid[i] && (src_addr[i] != 5'd0)) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (!opFound[i] && stg_ld_regfile[k] && (stg_dest[k] == src_addr[i])) begin
            opFound[i] = 1'b1;
            if (stg_ready[k]) begin
              fwd_hit[i]  = 1'b1;
              fwd_data[i] = stg_data[k];
              fwd_src[i]  = SW'(k);
            end else begin
              opStall[i] = 1'b1;
            end
          end
        end
        if (!opFound[i]) begin
          if (lat_done && (lat_done_dest == src_addr[i])) begin
            fwd_hit[i]  = 1'b1;
            fwd_data[i] = lat_done_data;
            fwd_src[i]  = SW'(NUM_STAGES);
          end else if (sb_busy[src_addr[i]]) begin
            opStall[i] = 1'b1;
          end
        end
      end
    end
  end

  assign stallInt = |opStall;
  assign stall    = stallInt;

  // Watchdog: count consecutive stall cycles and latch a timeout flag once
  // TIMEOUT of them have completed; only timeout_clr leaves TOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      stallCnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (stallInt) begin
            state_q    <= WAIT;
            stallCnt_q <= CW'(1);
          end else begin
            stallCnt_q <= '0;
          end
        end
        WAIT: begin
          if (!stallInt) begin
            state_q    <= RUN;
            stallCnt_q <= '0;
          end else if (stallCnt_q == CW'(TIMEOUT - 1)) begin
            state_q    <= TOUT;
            stallCnt_q <= CW'(TIMEOUT);
            timeout_q  <= 1'b1;
          end else begin
            stallCnt_q <= stallCnt_q + CW'(1);
          end
        end
        TOUT: begin
          if (timeout_clr) begin
            state_q    <= RUN;
            stallCnt_q <= '0;
            timeout_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= RUN;
          stallCnt_q <= '0;
          timeout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hazard_timeout = timeout_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios followed by
// random traffic, all compared against a behavioural model of the rules.
module tb_fwd_hazard_unit;

  localparam int NS = 2;
  localparam int NG = 2;
  localparam int TO = 4;
  localparam int SW = $clog2(NG + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NS-1:0]        srcValid;
  logic [NS-1:0][4:0]   srcAddr;
  logic [NG-1:0]        stgLd;
  logic [NG-1:0][4:0]   stgDest;
  logic [NG-1:0][31:0]  stgData;
  logic [NG-1:0]        stgReady;
  logic                 latIssue;
  logic [4:0]           latIssueDest;
  logic                 latDone;
  logic [4:0]           latDoneDest;
  logic [31:0]          latDoneData;
  logic                 timeoutClr;
  logic [NS-1:0]        fwdHit;
  logic [NS-1:0][31:0]  fwdData;
  logic [NS-1:0][SW-1:0] fwdSrc;
  logic                 stallOut;
  logic [31:0]          sbBusy;
  logic                 hazTimeout;

  int testsRun  = 0;
  int failCount = 0;

  // Behavioural model state
  logic [31:0] modelBusy;
  int          runLen;
  logic        modelFlag;
  logic [NS-1:0]       expHit;
  logic [NS-1:0][31:0] expData;
  int                  expSrc [NS];
  logic                expStall;

  fwd_hazard_unit #(.NUM_SRC(NS), .NUM_STAGES(NG), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .src_valid      (srcValid),
    .src_addr       (srcAddr),
    .stg_ld_regfile (stgLd),
    .stg_dest       (stgDest),
    .stg_data       (stgData),
    .stg_ready      (stgReady),
    .lat_issue      (latIssue),
    .lat_issue_dest (latIssueDest),
    .lat_done       (latDone),
    .lat_done_dest  (latDoneDest),
    .lat_done_data  (latDoneData),
    .timeout_clr    (timeoutClr),
    .fwd_hit        (fwdHit),
    .fwd_data       (fwdData),
    .fwd_src        (fwdSrc),
    .stall          (stallOut),
    .sb_busy        (sbBusy),
    .hazard_timeout (hazTimeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    srcValid = '0; srcAddr = '0;
    stgLd = '0; stgDest = '0; stgData = '0; stgReady = '0;
    latIssue = 1'b0; latIssueDest = '0;
    latDone = 1'b0; latDoneDest = '0; latDoneData = '0;
    timeoutClr = 1'b0;
  endtask

  // Expected combinational outputs from the forwarding rules
  task automatic evalModel();
    expStall = 1'b0;
    for (int i = 0; i < NS; i++) begin
      expHit[i] = 1'b0; expData[i] = '0; expSrc[i] = 0;
      if (srcValid[i] && srcAddr[i] != 0) begin
        int winner;
        winner = -1;
        for (int k = 0; k < NG; k++)
          if (winner < 0 && stgLd[k] && stgDest[k] == srcAddr[i]) winner = k;
        if (winner >= 0) begin
          if (stgReady[winner]) begin
            expHit[i] = 1'b1; expData[i] = stgData[winner]; expSrc[i] = winner;
          end else expStall = 1'b1;
        end else if (latDone && latDoneDest == srcAddr[i]) begin
          expHit[i] = 1'b1; expData[i] = latDoneData; expSrc[i] = NG;
        end else if (modelBusy[srcAddr[i]]) expStall = 1'b1;
      end
    end
  endtask

  task automatic modelClock();
    if (latDone) modelBusy[latDoneDest] = 1'b0;
    if (latIssue && latIssueDest != 0) modelBusy[latIssueDest] = 1'b1;
    if (modelFlag) begin
      if (timeoutClr) begin modelFlag = 1'b0; runLen = 0; end
    end else if (expStall) begin
      runLen++;
      if (runLen >= TO) modelFlag = 1'b1;
    end else runLen = 0;
  endtask

  task automatic modelReset();
    modelBusy = '0; runLen = 0; modelFlag = 1'b0;
  endtask

  // Check all outputs for the current inputs, then advance one cycle
  task automatic cycleCheck(input string tag);
    #1;
    evalModel();
    for (int i = 0; i < NS; i++) begin
      checkOutput($sformatf("%s.hit%0d", tag, i), 32'(fwdHit[i]), 32'(expHit[i]));
      checkOutput($sformatf("%s.data%0d", tag, i), fwdData[i], expData[i]);
      if (expHit[i])
        checkOutput($sformatf("%s.src%0d", tag, i), 32'(fwdSrc[i]), 32'(expSrc[i]));
    end
    checkOutput($sformatf("%s.stall", tag), 32'(stallOut), 32'(expStall));
    checkOutput($sformatf("%s.busy", tag), sbBusy, modelBusy);
    checkOutput($sformatf("%s.tout", tag), 32'(hazTimeout), 32'(modelFlag));
    @(posedge clk);
    modelClock();
    @(negedge clk);
  endtask

  initial begin
    modelReset();
    applyStimulus();
    // Reset with busy-looking inputs: everything must read zero
    srcValid = 2'b11; srcAddr[0] = 5'd5; srcAddr[1] = 5'd7;
    stgLd = 2'b11; stgDest[0] = 5'd5; stgDest[1] = 5'd7;
    stgData[0] = 32'h1111; stgData[1] = 32'h2222; stgReady = 2'b01;
    #12;
    checkOutput("rst.hit", 32'(fwdHit), 32'd0);
    checkOutput("rst.data0", fwdData[0], 32'd0);
    checkOutput("rst.src", 32'(fwdSrc), 32'd0);
    checkOutput("rst.stall", 32'(stallOut), 32'd0);
    checkOutput("rst.busy", sbBusy, 32'd0);
    checkOutput("rst.tout", 32'(hazTimeout), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus();

    // Youngest stage wins
    srcValid = 2'b01; srcAddr[0] = 5'd5;
    stgLd = 2'b11; stgDest[0] = 5'd5; stgDest[1] = 5'd5;
    stgData[0] = 32'hAAAA; stgData[1] = 32'hBBBB; stgReady = 2'b11;
    #1;
    checkOutput("young.data", fwdData[0], 32'hAAAA);
    checkOutput("young.src", 32'(fwdSrc[0]), 32'd0);
    cycleCheck("young");

    // Load-use: not-ready youngest producer stalls, no fallback
    applyStimulus();
    srcValid = 2'b10; srcAddr[1] = 5'd7;
    stgLd = 2'b11; stgDest[0] = 5'd7; stgDest[1] = 5'd7;
    stgData[1] = 32'h7777; stgReady = 2'b10;
    #1;
    checkOutput("ldu.stall", 32'(stallOut), 32'd1);
    checkOutput("ldu.hit1", 32'(fwdHit[1]), 32'd0);
    cycleCheck("ldu");

    // x0 is never forwarded
    applyStimulus();
    srcValid = 2'b01; srcAddr[0] = 5'd0;
    stgLd = 2'b01; stgDest[0] = 5'd0; stgData[0] = 32'h1234; stgReady = 2'b01;
    #1;
    checkOutput("x0.data", fwdData[0], 32'd0);
    cycleCheck("x0");

    // Long-latency x9: scoreboard stall then lat_done bypass
    applyStimulus();
    latIssue = 1'b1; latIssueDest = 5'd9;
    cycleCheck("iss9");
    applyStimulus();
    srcValid = 2'b01; srcAddr[0] = 5'd9;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("sb9.stall", 32'(stallOut), 32'd1);
      cycleCheck("sb9");
    end
    latDone = 1'b1; latDoneDest = 5'd9; latDoneData = 32'h55;
    #1;
    checkOutput("byp9.data", fwdData[0], 32'h55);
    checkOutput("byp9.src", 32'(fwdSrc[0]), NG);
    checkOutput("byp9.stall", 32'(stallOut), 32'd0);
    cycleCheck("byp9");
    applyStimulus();
    #1;
    checkOutput("clr9.busy", 32'(sbBusy[9]), 32'd0);
    cycleCheck("clr9");

    // Same-cycle issue and done on x3 keeps it busy
    latIssue = 1'b1; latIssueDest = 5'd3;
    cycleCheck("iss3");
    latDone = 1'b1; latDoneDest = 5'd3;
    cycleCheck("both3");
    applyStimulus();
    #1;
    checkOutput("keep3.busy", 32'(sbBusy[3]), 32'd1);
    latDone = 1'b1; latDoneDest = 5'd3;
    cycleCheck("done3");
    applyStimulus();

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      srcValid = NS'($urandom);
      for (int i = 0; i < NS; i++) srcAddr[i] = 5'($urandom_range(0, 7));
      stgLd = NG'($urandom); stgReady = NG'($urandom);
      for (int k = 0; k < NG; k++) begin
        stgDest[k] = 5'($urandom_range(0, 7));
        stgData[k] = $urandom;
      end
      latIssue = ($urandom_range(0, 3) == 0);
      latIssueDest = 5'($urandom_range(0, 7));
      latDone = ($urandom_range(0, 2) == 0);
      latDoneDest = 5'($urandom_range(0, 7));
      latDoneData = $urandom;
      timeoutClr = ($urandom_range(0, 5) == 0);
      cycleCheck("rand");
    end

    // Quiesce the watchdog before the directed timeout run
    applyStimulus();
    timeoutClr = 1'b1;
    cycleCheck("quiet");
    applyStimulus();
    cycleCheck("idle");

    // Four consecutive load-use stalls fire the watchdog
    latIssue = 1'b1; latIssueDest = 5'd12;
    srcValid = 2'b01; srcAddr[0] = 5'd7;
    stgLd = 2'b01; stgDest[0] = 5'd7; stgReady = 2'b00;
    for (int c = 0; c < TO; c++) begin
      #1;
      checkOutput("wd.pre", 32'(hazTimeout), 32'd0);
      cycleCheck("wd");
      latIssue = 1'b0;
    end
    #1;
    checkOutput("wd.fired", 32'(hazTimeout), 32'd1);

    // Asynchronous reset in TOUT clears everything immediately
    #1 rst = 1'b0;
    #1;
    modelReset();
    checkOutput("arst.tout", 32'(hazTimeout), 32'd0);
    checkOutput("arst.busy", sbBusy, 32'd0);
    checkOutput("arst.stall", 32'(stallOut), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus();
    srcValid = 2'b01; srcAddr[0] = 5'd12;
    #1;
    checkOutput("post.stall", 32'(stallOut), 32'd0);
    cycleCheck("post");
    cycleCheck("post2");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  // Overall time bound so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    failCount++;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
